// File: rtl/obi_sram_responder.sv
// OBI subordinate backed by a word-addressed SRAM with programmable grant wait states.
// Latency: gnt after WAIT_STATES cycles of req; rvalid/rdata registered one cycle after gnt.
// Backpressure: initiator is stalled by withholding gnt; one response per grant, never outstanding >1.

package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module obi_sram_responder #(
  parameter int unsigned NUM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ERR_RDATA   = 32'hBADC_AB1E
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  obi_pkg::obi_req_t   bus_req_i,
  output obi_pkg::obi_resp_t  bus_resp_o,
  output logic [31:0]         access_cnt_o
);

  localparam int unsigned AW = $clog2(NUM_WORDS);
  // Counter load value; only meaningful when WAIT_STATES > 0.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            gnt;
  logic            rvalid_q;
  logic [31:0]     rdata_q;
  logic [31:0]     access_cnt_q;
  logic [31:0]     mem [NUM_WORDS];

  // Address decode: unsigned subtraction makes addresses below BASE_ADDR wrap out of range.
  logic [31:0]     offset;
  logic            in_range;
  logic [AW-1:0]   idx;
  logic            unused_offset_bits;

  assign offset             = bus_req_i.addr - BASE_ADDR;
  assign in_range           = ({2'b00, offset[31:2]} < NUM_WORDS);
  assign idx                = offset[AW+1:2];
  assign unused_offset_bits = ^offset[1:0];

  // Next-state and grant: wait-state countdown, abort on req drop, gnt forced low in reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (WAIT_STATES == 0) begin
          gnt = bus_req_i.req;
        end else if (bus_req_i.req) begin
          cnt_d   = WAIT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!bus_req_i.req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          gnt     = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      gnt = 1'b0;
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Byte-lane write on the grant edge; out-of-range writes are dropped. Array is not reset.
  always_ff @(posedge clk_i) begin
    if (gnt && bus_req_i.we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_req_i.be[i]) begin
          mem[idx][8*i +: 8] <= bus_req_i.wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered response and grant counter; the read sees any write committed on the prior edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'h0;
      access_cnt_q <= 32'h0;
    end else begin
      rvalid_q <= gnt;
      if (gnt) begin
        access_cnt_q <= access_cnt_q + 32'd1;
        if (bus_req_i.we) begin
          rdata_q <= 32'h0;
        end else if (in_range) begin
          rdata_q <= mem[idx];
        end else begin
          rdata_q <= ERR_RDATA;
        end
      end
    end
  end

  // rvalid is also masked while reset is held, so a reset raised right after a grant hides that response.
  always_comb begin
    bus_resp_o.gnt    = gnt;
    bus_resp_o.rvalid = rvalid_q & ~rst_i;
    bus_resp_o.rdata  = rdata_q;
  end

  assign access_cnt_o = access_cnt_q;

endmodule

// File: tb/tb_obi_sram_responder.sv
// Directed bench for obi_sram_responder: zero-wait instance at base 0 and a 3-wait instance at 0x8000_0000.
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after the edge.
// Responses are checked one cycle after the grant they belong to.

module tb_obi_sram_responder;
  import obi_pkg::*;

  logic               clk;
  logic               rst;
  obi_req_t           req0, req3;
  obi_resp_t          resp0, resp3;
  logic [31:0]        cnt0, cnt3;
  int                 tests;
  int                 fails;
  int                 ngnt;
  int                 nrv;

  localparam obi_req_t IDLE_REQ = '{req: 1'b0, we: 1'b0, be: 4'h0, addr: 32'h0, wdata: 32'h0};

  obi_sram_responder #(
    .NUM_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0), .ERR_RDATA(32'hBADC_AB1E)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .bus_req_i(req0), .bus_resp_o(resp0), .access_cnt_o(cnt0)
  );

  obi_sram_responder #(
    .NUM_WORDS(16), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(3), .ERR_RDATA(32'hBADC_AB1E)
  ) u_dut3 (
    .clk_i(clk), .rst_i(rst), .bus_req_i(req3), .bus_resp_o(resp3), .access_cnt_o(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go0(input logic r, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    req0 = '{req: r, we: w, be: b, addr: a, wdata: d};
    #1;
  endtask

  task automatic go3(input logic r, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    req3 = '{req: r, we: w, be: b, addr: a, wdata: d};
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    req0  = IDLE_REQ;
    req3  = IDLE_REQ;
    repeat (2) @(posedge clk);

    // Reset state; a request under reset must not be granted.
    go0(1'b1, 1'b1, 4'hF, 32'h0, 32'hFFFF_FFFF);
    chk("rst_gnt0", 32'(resp0.gnt), 32'h0);
    chk("rst_rvalid0", 32'(resp0.rvalid), 32'h0);
    chk("rst_rdata0", resp0.rdata, 32'h0);
    chk("rst_cnt0", cnt0, 32'h0);
    chk("rst_rvalid3", 32'(resp3.rvalid), 32'h0);
    chk("rst_cnt3", cnt3, 32'h0);
    req0 = IDLE_REQ;
    rst  = 1'b0;

    // 1: write then read at 0x10, zero wait states.
    go0(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    chk("t1_wr_gnt", 32'(resp0.gnt), 32'h1);
    chk("t1_wr_no_rvalid", 32'(resp0.rvalid), 32'h0);
    go0(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    chk("t1_rd_gnt", 32'(resp0.gnt), 32'h1);
    chk("t1_wr_rvalid", 32'(resp0.rvalid), 32'h1);
    chk("t1_wr_rdata", resp0.rdata, 32'h0);
    go0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("t1_idle_gnt", 32'(resp0.gnt), 32'h0);
    chk("t1_rd_rvalid", 32'(resp0.rvalid), 32'h1);
    chk("t1_rd_rdata", resp0.rdata, 32'hDEAD_BEEF);
    chk("t1_cnt", cnt0, 32'd2);
    go0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("t1_rvalid_single", 32'(resp0.rvalid), 32'h0);

    // 2: byte enables.
    go0(1'b1, 1'b1, 4'hF, 32'h20, 32'h1122_3344);
    go0(1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
    go0(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    go0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("t2_be_rvalid", 32'(resp0.rvalid), 32'h1);
    chk("t2_be_rdata", resp0.rdata, 32'h11BB_33DD);
    chk("t2_cnt", cnt0, 32'd5);

    // 4: out-of-range read returns the error pattern; out-of-range write is dropped.
    go0(1'b1, 1'b1, 4'hF, 32'h0, 32'h0000_1111);
    go0(1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
    chk("t4_oor_rd_gnt", 32'(resp0.gnt), 32'h1);
    go0(1'b1, 1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF);
    chk("t4_oor_wr_gnt", 32'(resp0.gnt), 32'h1);
    chk("t4_oor_rd_rvalid", 32'(resp0.rvalid), 32'h1);
    chk("t4_oor_rd_rdata", resp0.rdata, 32'hBADC_AB1E);
    go0(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    chk("t4_oor_wr_rvalid", 32'(resp0.rvalid), 32'h1);
    chk("t4_oor_wr_rdata", resp0.rdata, 32'h0);
    go0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("t4_word0_kept", resp0.rdata, 32'h0000_1111);
    chk("t4_cnt", cnt0, 32'd9);

    // 5b: reset the cycle after a grant; a write presented under reset is not committed.
    go0(1'b1, 1'b1, 4'hF, 32'h190, 32'h0000_2222);
    chk("t5_pre_gnt", 32'(resp0.gnt), 32'h1);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    req0 = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'h190, wdata: 32'hFFFF_FFFF};
    #1;
    chk("t5_rst_gnt", 32'(resp0.gnt), 32'h0);
    chk("t5_rst_rvalid", 32'(resp0.rvalid), 32'h0);
    go0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("t5_rst_cnt", cnt0, 32'h0);
    chk("t5_rst_rvalid2", 32'(resp0.rvalid), 32'h0);
    chk("t5_rst_rdata", resp0.rdata, 32'h0);
    rst = 1'b0;

    // 6: streaming 16 writes then 16 reads, one per cycle.
    ngnt = 0;
    nrv  = 0;
    for (int i = 0; i < 16; i++) begin
      go0(1'b1, 1'b1, 4'hF, 32'(i * 4), 32'h1000_0000 + 32'(i));
      ngnt += int'(resp0.gnt);
      nrv  += int'(resp0.rvalid);
      if (i > 0) chk("t6_wr_rdata", resp0.rdata, 32'h0);
    end
    for (int i = 0; i < 16; i++) begin
      go0(1'b1, 1'b0, 4'hF, 32'(i * 4), 32'h0);
      ngnt += int'(resp0.gnt);
      nrv  += int'(resp0.rvalid);
      if (i > 0) chk("t6_rd_rdata", resp0.rdata, 32'h1000_0000 + 32'(i - 1));
    end
    go0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    nrv += int'(resp0.rvalid);
    chk("t6_last_rdata", resp0.rdata, 32'h1000_000F);
    chk("t6_ngnt", 32'(ngnt), 32'd32);
    chk("t6_nrv", 32'(nrv), 32'd32);
    chk("t6_cnt", cnt0, 32'd32);
    go0(1'b1, 1'b0, 4'hF, 32'h190, 32'h0);
    go0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("t5_rst_write_dropped", resp0.rdata, 32'h0000_2222);

    // 3: three wait states, held req; grants in cycles 3 and 7.
    for (int k = 0; k < 8; k++) begin
      if (k < 4) go3(1'b1, 1'b1, 4'hF, 32'h8000_0004, 32'hCAFE_0001);
      else       go3(1'b1, 1'b0, 4'hF, 32'h8000_0004, 32'h0);
      chk($sformatf("t3_gnt_c%0d", k), 32'(resp3.gnt), (k == 3 || k == 7) ? 32'h1 : 32'h0);
      if (k == 4) begin
        chk("t3_wr_rvalid", 32'(resp3.rvalid), 32'h1);
        chk("t3_wr_rdata", resp3.rdata, 32'h0);
      end
    end
    go3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("t3_rd_rvalid", 32'(resp3.rvalid), 32'h1);
    chk("t3_rd_rdata", resp3.rdata, 32'hCAFE_0001);
    chk("t3_cnt", cnt3, 32'd2);

    // 5a: req dropped mid-wait aborts; a fresh request then needs the full three cycles.
    go3(1'b1, 1'b0, 4'hF, 32'h8000_0008, 32'h0);
    chk("t5_abort_c0_gnt", 32'(resp3.gnt), 32'h0);
    go3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("t5_abort_c1_gnt", 32'(resp3.gnt), 32'h0);
    for (int k = 0; k < 3; k++) begin
      go3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      chk("t5_abort_idle_gnt", 32'(resp3.gnt), 32'h0);
      chk("t5_abort_rvalid", 32'(resp3.rvalid), 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      go3(1'b1, 1'b0, 4'hF, 32'h7FFF_FFFC, 32'h0);
      chk($sformatf("t5_fresh_gnt_c%0d", k), 32'(resp3.gnt), (k == 3) ? 32'h1 : 32'h0);
    end
    go3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("t5_below_base_rvalid", 32'(resp3.rvalid), 32'h1);
    chk("t5_below_base_rdata", resp3.rdata, 32'hBADC_AB1E);
    chk("t5_cnt3", cnt3, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
